memory_responder: RTL and testbench

MEMORY_RESPONDER -- requirements
Module: memory_responder

---
 rtl/memory_responder_pkg.sv | 28 ++
 rtl/byte_ram.sv | 29 ++
 rtl/memory_responder.sv | 126 ++++++++++++
 tb/tb_memory_responder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/memory_responder_pkg.sv
// Shared constants for the load/store responder: funct3 codes, control-bit
// layout and FSM state encoding, also used by the cpu controller.
package memory_responder_pkg;

  localparam int STORE_BIT = 3;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RESPOND = 2'd2
  } state_t;

  function automatic logic f3_legal(input logic store, input logic [2:0] f3);
    if (store) return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

endpackage

// File: rtl/byte_ram.sv
// Single-port WORDS x 32 RAM with per-byte write enables and registered read.
// Contents are never reset.
module byte_ram #(
  parameter int WORDS = 1024,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clock,
  input  logic          we,
  input  logic          re,
  input  logic [3:0]    be,
  input  logic [AW-1:0] index,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  // One 8-bit array per lane so each maps onto a plain byte-wide RAM.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem [WORDS];
    logic [7:0] q_reg;

    always_ff @(posedge clock) begin
      if (we && be[gi]) mem[index] <= wdata[gi*8 +: 8];
      if (re) q_reg <= mem[index];
    end

    assign rdata[gi*8 +: 8] = q_reg;
  end

endmodule

// File: rtl/memory_responder.sv
// RV32I load/store responder: latches one request, accesses byte_ram in
// ACCESS, and returns an extended result with a one-cycle ready in RESPOND.
module memory_responder
  import memory_responder_pkg::*;
#(
  parameter int WORDS = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        request,
  input  logic [3:0]  memory_control,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        error
);

  localparam int          AW         = $clog2(WORDS);
  localparam logic [32:0] BYTE_LIMIT = 33'(WORDS) * 33'd4;

  state_t      state_reg, state_next;
  logic [31:0] addr_reg, wdata_reg, rdata_reg;
  logic [3:0]  ctrl_reg;

  logic        is_store, misaligned, out_of_range, access_err;
  logic [2:0]  f3;
  logic [1:0]  size;
  logic [3:0]  be;
  logic [31:0] lane_wdata, ram_rdata, shifted, load_value, response_data;
  logic        ram_we, ram_re;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (request) state_next = ST_ACCESS;
      ST_ACCESS:  state_next = ST_RESPOND;
      ST_RESPOND: state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_reg  <= '0;
      ctrl_reg  <= '0;
      wdata_reg <= '0;
    end else if (state_reg == ST_IDLE && request) begin
      addr_reg  <= address;
      ctrl_reg  <= memory_control;
      wdata_reg <= write_data;
    end
  end

  // Range check uses the full address so high bits cannot alias into the RAM.
  always_comb begin
    is_store     = ctrl_reg[STORE_BIT];
    f3           = ctrl_reg[2:0];
    size         = f3[1:0];
    misaligned   = (size == 2'b01 && addr_reg[0]) ||
                   (size == 2'b10 && addr_reg[1:0] != 2'b00);
    out_of_range = {1'b0, addr_reg} >= BYTE_LIMIT;
    access_err   = !f3_legal(is_store, f3) || misaligned || out_of_range;
  end

  always_comb begin
    be         = 4'b1111;
    lane_wdata = wdata_reg;
    case (size)
      2'b00: begin
        be         = 4'b0001 << addr_reg[1:0];
        lane_wdata = {4{wdata_reg[7:0]}};
      end
      2'b01: begin
        be         = addr_reg[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{wdata_reg[15:0]}};
      end
      default: ;
    endcase
  end

  assign ram_we = (state_reg == ST_ACCESS) && is_store && !access_err;
  assign ram_re = (state_reg == ST_ACCESS) && !is_store;

  byte_ram #(.WORDS(WORDS)) u_ram (
    .clock (clock),
    .we    (ram_we),
    .re    (ram_re),
    .be    (be),
    .index (addr_reg[AW+1:2]),
    .wdata (lane_wdata),
    .rdata (ram_rdata)
  );

  always_comb begin
    shifted = ram_rdata >> {addr_reg[1:0], 3'b000};
    case (f3)
      F3_LB:   load_value = {{24{shifted[7]}}, shifted[7:0]};
      F3_LH:   load_value = {{16{shifted[15]}}, shifted[15:0]};
      F3_LBU:  load_value = {24'd0, shifted[7:0]};
      F3_LHU:  load_value = {16'd0, shifted[15:0]};
      default: load_value = shifted;
    endcase
    if (access_err)    response_data = '0;
    else if (is_store) response_data = rdata_reg;
    else               response_data = load_value;
  end

  // Holds the last response so read_data stays stable between accesses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                        rdata_reg <= '0;
    else if (state_reg == ST_RESPOND) rdata_reg <= response_data;
  end

  always_comb begin
    ready     = (state_reg == ST_RESPOND);
    error     = ready && access_err;
    read_data = ready ? response_data : rdata_reg;
  end

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder with a byte-level reference model and
// a per-cycle compare process.
module tb_memory_responder;

  localparam int WORDS = 1024;
  localparam int BYTES = WORDS * 4;

  localparam logic [3:0] C_LB  = 4'b0000;
  localparam logic [3:0] C_LH  = 4'b0001;
  localparam logic [3:0] C_LW  = 4'b0010;
  localparam logic [3:0] C_LBU = 4'b0100;
  localparam logic [3:0] C_LHU = 4'b0101;
  localparam logic [3:0] C_SB  = 4'b1000;
  localparam logic [3:0] C_SH  = 4'b1001;
  localparam logic [3:0] C_SW  = 4'b1010;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        request = 1'b0;
  logic [3:0]  memory_control = '0;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        ready;
  logic        error;

  always #5 clock = ~clock;

  memory_responder #(.WORDS(WORDS)) dut (
    .clock          (clock),
    .reset          (reset),
    .request        (request),
    .memory_control (memory_control),
    .address        (address),
    .write_data     (write_data),
    .read_data      (read_data),
    .ready          (ready),
    .error          (error)
  );

  typedef struct {
    int          due;
    logic        is_store;
    logic        err;
    logic [31:0] rd;
  } resp_t;

  resp_t       pend[$];
  resp_t       cur;
  logic [7:0]  mem_m [BYTES];
  logic [31:0] held = '0;
  logic [31:0] exp_rd;
  logic [31:0] last_rd = '0;
  logic        last_err = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  always @(posedge clock) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference behaviour: byte-addressed memory, size/sign rules, error rules.
  function automatic void model(input logic [3:0] ctrl, input logic [31:0] a,
                                input logic [31:0] wd, output logic e,
                                output logic [31:0] rd);
    logic       st = ctrl[3];
    logic [2:0] f3 = ctrl[2:0];
    int         size = 1 << f3[1:0];
    longint     ab = longint'(a);
    logic       legal;
    legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    e  = !legal || (ab % size != 0) || (ab >= BYTES);
    rd = '0;
    if (e) return;
    if (st) begin
      for (int i = 0; i < size; i++) mem_m[int'(ab) + i] = wd[8*i +: 8];
    end else begin
      for (int i = 0; i < size; i++) rd[8*i +: 8] = mem_m[int'(ab) + i];
      if (!f3[2] && size == 1) rd[31:8]  = {24{rd[7]}};
      if (!f3[2] && size == 2) rd[31:16] = {16{rd[15]}};
    end
  endfunction

  always @(negedge clock) begin
    if (!reset) begin
      chk("reset_ready", {31'd0, ready}, 32'd0);
      chk("reset_error", {31'd0, error}, 32'd0);
      chk("reset_rdata", read_data, 32'd0);
      pend.delete();
      held = '0;
    end else if (pend.size() > 0 && pend[0].due == cyc) begin
      cur    = pend.pop_front();
      exp_rd = (cur.is_store && !cur.err) ? held : cur.rd;
      chk("resp_ready", {31'd0, ready}, 32'd1);
      chk("resp_error", {31'd0, error}, {31'd0, cur.err});
      chk("resp_rdata", read_data, exp_rd);
      held     = exp_rd;
      last_rd  = read_data;
      last_err = error;
      $display("resp cycle=%0d rdata=%h error=%b", cyc, read_data, error);
    end else begin
      chk("idle_ready", {31'd0, ready}, 32'd0);
      chk("idle_rdata_hold", read_data, held);
    end
  end

  task automatic push_expected(input logic [3:0] ctrl, input logic [31:0] a,
                               input logic [31:0] wd, input int due);
    resp_t       r;
    logic        e;
    logic [31:0] rd;
    model(ctrl, a, wd, e, rd);
    r.due = due; r.is_store = ctrl[3]; r.err = e; r.rd = rd;
    pend.push_back(r);
  endtask

  // Called on a negedge with the DUT idle; returns on the negedge where the
  // next request can be accepted.
  task automatic access(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] wd);
    int k;
    memory_control = ctrl; address = a; write_data = wd; request = 1'b1;
    k = cyc;
    $display("access ctrl=%b addr=%h wdata=%h", ctrl, a, wd);
    @(posedge clock);
    push_expected(ctrl, a, wd, k + 2);
    #1;
    request = 1'b0;
    memory_control = 4'($urandom);
    address = $urandom;
    write_data = $urandom;
    repeat (3) @(negedge clock);
  endtask

  task automatic lit(input string name, input logic [31:0] rd, input logic e);
    chk({name, "_rdata"}, last_rd, rd);
    chk({name, "_error"}, {31'd0, last_err}, {31'd0, e});
  endtask

  logic [31:0] hold_addr [9];

  initial begin
    hold_addr = '{32'h10, 32'h11, 32'h13, 32'h20, 32'h22, 32'h1, 32'hFFC, 32'h3, 32'h5};
    repeat (3) @(negedge clock);
    reset = 1'b1;

    access(C_SW, 32'h10, 32'hDEADBEEF);  lit("sw_keeps_rdata", 32'h0, 1'b0);
    access(C_LW, 32'h10, 32'h0);         lit("lw_10", 32'hDEADBEEF, 1'b0);
    access(C_SB, 32'h12, 32'hAAAAAA55);
    access(C_LW, 32'h10, 32'h0);         lit("lw_after_sb", 32'hDE55BEEF, 1'b0);
    access(C_LB, 32'h13, 32'h0);         lit("lb_13", 32'hFFFFFFDE, 1'b0);
    access(C_LBU, 32'h13, 32'h0);        lit("lbu_13", 32'h000000DE, 1'b0);
    access(C_LH, 32'h12, 32'h0);         lit("lh_12", 32'hFFFFDE55, 1'b0);
    access(C_LHU, 32'h12, 32'h0);        lit("lhu_12", 32'h0000DE55, 1'b0);

    access(C_LW, 32'h11, 32'h0);         lit("lw_misaligned", 32'h0, 1'b1);
    access(C_SH, 32'h13, 32'hFFFF);      lit("sh_misaligned", 32'h0, 1'b1);
    access(C_LW, BYTES, 32'h0);          lit("lw_out_of_range", 32'h0, 1'b1);
    access(C_LW, 32'h80000010, 32'h0);   lit("lw_no_alias", 32'h0, 1'b1);
    access(4'b1011, 32'h10, 32'h0);      lit("store_f3_011", 32'h0, 1'b1);
    access(4'b0110, 32'h10, 32'h0);      lit("load_f3_110", 32'h0, 1'b1);
    access(C_LW, 32'h10, 32'h0);         lit("mem_unchanged", 32'hDE55BEEF, 1'b0);

    access(C_SW, BYTES - 4, 32'h0BADC0DE);
    access(C_LW, BYTES - 4, 32'h0);      lit("lw_last_word", 32'h0BADC0DE, 1'b0);
    access(C_SH, 32'h16, 32'h1234BEEF);
    access(C_LH, 32'h16, 32'h0);         lit("lh_16", 32'hFFFFBEEF, 1'b0);

    // Reset during ACCESS must cancel the pending store and its response.
    access(C_SW, 32'h20, 32'hCAFEF00D);
    memory_control = C_SW; address = 32'h20; write_data = 32'h12345678; request = 1'b1;
    $display("access ctrl=%b addr=%h wdata=%h (interrupted)", C_SW, 32'h20, 32'h12345678);
    @(posedge clock);
    #1;
    request = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    access(C_LW, 32'h20, 32'h0);         lit("reset_cancels_store", 32'hCAFEF00D, 1'b0);

    // Request held high with changing inputs: only every third edge accepts.
    request = 1'b1;
    for (int i = 0; i < 9; i++) begin
      address = hold_addr[i];
      write_data = $urandom;
      memory_control = (i % 3 == 0) ? C_LW : C_SW;
      if (i % 3 == 0) begin
        $display("access ctrl=%b addr=%h (held request)", C_LW, hold_addr[i]);
        push_expected(C_LW, hold_addr[i], 32'h0, cyc + 2);
      end
      @(negedge clock);
    end
    request = 1'b0;
    access(C_LW, 32'h10, 32'h0);         lit("held_no_stray_store", 32'hDE55BEEF, 1'b0);

    repeat (4) @(negedge clock);
    chk("queue_drained", 32'(pend.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
